// File: rtl/alu_issue_queue_if.sv
// Shared packet type and the dispatch/CDB/issue bundle of the ALU issue queue.
package alu_iq_pkg;
  localparam int PREG_W = 6;

  typedef struct packed {
    logic              valid;
    logic [3:0]        alu_op;
    logic [4:0]        rd_rob_idx;
    logic [PREG_W-1:0] rd_paddr;
    logic [PREG_W-1:0] rs1_paddr;
    logic [PREG_W-1:0] rs2_paddr;
    logic [31:0]       rs1_data;
    logic [31:0]       rs2_data;
  } reservation_station_t;
endpackage

interface alu_issue_queue_if #(parameter int DEPTH = 8);
  alu_iq_pkg::reservation_station_t dispatch_entry;
  alu_iq_pkg::reservation_station_t next_execute;
  logic                         flush;
  logic                         dispatch_valid;
  logic                         dispatch_rs1_ready;
  logic                         dispatch_rs2_ready;
  logic                         dispatch_ready;
  logic                         cdb_valid;
  logic [alu_iq_pkg::PREG_W-1:0] cdb_rd_paddr;
  logic [31:0]                  cdb_rd_data;
  logic                         alu_ready;
  logic [$clog2(DEPTH):0]       occupancy;

  modport master (
    output flush, dispatch_valid, dispatch_entry, dispatch_rs1_ready, dispatch_rs2_ready,
           cdb_valid, cdb_rd_paddr, cdb_rd_data, alu_ready,
    input  dispatch_ready, next_execute, occupancy
  );

  modport slave (
    input  flush, dispatch_valid, dispatch_entry, dispatch_rs1_ready, dispatch_rs2_ready,
           cdb_valid, cdb_rd_paddr, cdb_rd_data, alu_ready,
    output dispatch_ready, next_execute, occupancy
  );
endinterface

// File: rtl/alu_issue_queue.sv
// ALU reservation station: CDB wakeup, one registered issue per cycle.
// Define ALU_IQ_AGE_SEL_EN for oldest-first select; default is lowest-index select.
module alu_issue_queue #(
  parameter int DEPTH  = 8,
  parameter int PREG_W = alu_iq_pkg::PREG_W
) (
  input logic              clk,
  input logic              rst,
  alu_issue_queue_if.slave iq
);
  localparam int IW = $clog2(DEPTH);
  typedef alu_iq_pkg::reservation_station_t rs_t;

  rs_t              entry_q [DEPTH];
  rs_t              entry_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  rs_t              nxt_q, nxt_d;
  logic [IW:0]      occ_q, occ_d;
  logic [DEPTH-1:0] elig;
  logic [IW-1:0]    sel, free_idx;
  logic             issue, do_disp, wake;

  assign elig    = valid_q & rdy1_q & rdy2_q;
  assign issue   = iq.alu_ready && (|elig);
  assign do_disp = iq.dispatch_valid && iq.dispatch_ready;
  assign wake    = iq.cdb_valid && (iq.cdb_rd_paddr != PREG_W'(0));

  assign iq.dispatch_ready = (occ_q < (IW+1)'(DEPTH));
  assign iq.next_execute   = nxt_q;
  assign iq.occupancy      = occ_q;

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (!valid_q[i]) free_idx = IW'(i);
  end

`ifdef ALU_IQ_AGE_SEL_EN
  logic [IW-1:0] age_q [DEPTH];
  logic [IW-1:0] age_d [DEPTH];
  logic [IW-1:0] best_age;
  logic          found;

  // Strict '>' keeps the lowest index on equal ages.
  always_comb begin
    sel      = '0;
    best_age = '0;
    found    = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (elig[i] && (!found || age_q[i] > best_age)) begin
        sel      = IW'(i);
        best_age = age_q[i];
        found    = 1'b1;
      end
  end
`else
  always_comb begin
    sel = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (elig[i]) sel = IW'(i);
  end
`endif

  always_comb begin
    valid_d = valid_q;
    rdy1_d  = rdy1_q;
    rdy2_d  = rdy2_q;
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = entry_q[i];
`ifdef ALU_IQ_AGE_SEL_EN
      age_d[i] = age_q[i];
      if (do_disp && valid_q[i] && age_q[i] != IW'(DEPTH-1))
        age_d[i] = age_q[i] + 1'b1;
`endif
      if (valid_q[i] && wake) begin
        if (!rdy1_q[i] && entry_q[i].rs1_paddr == iq.cdb_rd_paddr) begin
          rdy1_d[i]           = 1'b1;
          entry_d[i].rs1_data = iq.cdb_rd_data;
        end
        if (!rdy2_q[i] && entry_q[i].rs2_paddr == iq.cdb_rd_paddr) begin
          rdy2_d[i]           = 1'b1;
          entry_d[i].rs2_data = iq.cdb_rd_data;
        end
      end
    end

    if (issue) valid_d[sel] = 1'b0;

    // A dispatching entry snoops the CDB too, so a same-cycle broadcast is not lost.
    if (do_disp) begin
      valid_d[free_idx] = 1'b1;
      entry_d[free_idx] = iq.dispatch_entry;
      rdy1_d[free_idx]  = iq.dispatch_rs1_ready;
      rdy2_d[free_idx]  = iq.dispatch_rs2_ready;
      if (wake && !iq.dispatch_rs1_ready && iq.dispatch_entry.rs1_paddr == iq.cdb_rd_paddr) begin
        rdy1_d[free_idx]           = 1'b1;
        entry_d[free_idx].rs1_data = iq.cdb_rd_data;
      end
      if (wake && !iq.dispatch_rs2_ready && iq.dispatch_entry.rs2_paddr == iq.cdb_rd_paddr) begin
        rdy2_d[free_idx]           = 1'b1;
        entry_d[free_idx].rs2_data = iq.cdb_rd_data;
      end
`ifdef ALU_IQ_AGE_SEL_EN
      age_d[free_idx] = '0;
`endif
    end

    nxt_d = '0;
    if (issue) begin
      nxt_d       = entry_q[sel];
      nxt_d.valid = 1'b1;
    end

    occ_d = occ_q + (IW+1)'(do_disp) - (IW+1)'(issue);
  end

  always_ff @(posedge clk) begin
    if (rst || iq.flush) begin
      valid_q <= '0;
      nxt_q   <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      nxt_q   <= nxt_d;
      occ_q   <= occ_d;
    end
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    rdy1_q  <= rdy1_d;
    rdy2_q  <= rdy2_d;
    entry_q <= entry_d;
`ifdef ALU_IQ_AGE_SEL_EN
    age_q   <= age_d;
`endif
  end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: expected packets queued at stimulus, popped at issue.
module tb_alu_issue_queue;
  typedef alu_iq_pkg::reservation_station_t rs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0, n_pass = 0;
  rs_t  sbq[$];
  rs_t  e_mon;

  always #5 clk = ~clk;

  alu_issue_queue_if #(.DEPTH(8)) ifc ();
  alu_issue_queue #(.DEPTH(8), .PREG_W(6)) dut (.clk(clk), .rst(rst), .iq(ifc.slave));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic rs_t mk(input logic [3:0] op, input logic [5:0] p1, input logic [5:0] p2,
                             input logic [31:0] d1, input logic [31:0] d2, input logic [4:0] rob);
    rs_t e;
    e            = '0;
    e.alu_op     = op;
    e.rd_rob_idx = rob;
    e.rd_paddr   = 6'(rob) + 6'd1;
    e.rs1_paddr  = p1;
    e.rs2_paddr  = p2;
    e.rs1_data   = d1;
    e.rs2_data   = d2;
    return e;
  endfunction

  function automatic rs_t ex(input rs_t e);
    rs_t r;
    r       = e;
    r.valid = 1'b1;
    return r;
  endfunction

  task automatic disp(input rs_t e, input logic r1, input logic r2);
    ifc.dispatch_valid     = 1'b1;
    ifc.dispatch_entry     = e;
    ifc.dispatch_rs1_ready = r1;
    ifc.dispatch_rs2_ready = r2;
    tick();
    ifc.dispatch_valid     = 1'b0;
  endtask

  task automatic bcast(input logic [5:0] tag, input logic [31:0] d);
    ifc.cdb_valid    = 1'b1;
    ifc.cdb_rd_paddr = tag;
    ifc.cdb_rd_data  = d;
    tick();
    ifc.cdb_valid    = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && ifc.next_execute.valid) begin
      if (sbq.size() == 0) chk("unexpected_issue", ifc.next_execute.valid, 1'b0);
      else begin
        e_mon = sbq.pop_front();
        chk("issue_pkt", ifc.next_execute, e_mon);
      end
    end
  end

  initial begin
    rs_t e, a, b, c, d0, n;
    rs_t fe[8];
    ifc.flush = 0; ifc.dispatch_valid = 0; ifc.dispatch_entry = '0;
    ifc.dispatch_rs1_ready = 0; ifc.dispatch_rs2_ready = 0;
    ifc.cdb_valid = 0; ifc.cdb_rd_paddr = '0; ifc.cdb_rd_data = '0; ifc.alu_ready = 0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_occ", ifc.occupancy, 0);
    chk("rst_ready", ifc.dispatch_ready, 1);
    chk("rst_next", ifc.next_execute, 0);

    // ready ADD: issue two edges after dispatch
    ifc.alu_ready = 1;
    e = mk(4'd0, 6'd3, 6'd4, 32'd5, 32'd7, 5'd1);
    sbq.push_back(ex(e));
    disp(e, 1, 1);
    chk("add_occ1", ifc.occupancy, 1);
    chk("add_not_yet", ifc.next_execute.valid, 0);
    tick();
    chk("add_issue", ifc.next_execute.valid, 1);
    chk("add_occ0", ifc.occupancy, 0);

    // tag 0 broadcast must not wake
    e = mk(4'd1, 6'd0, 6'd5, 32'd0, 32'd9, 5'd2);
    disp(e, 0, 1);
    bcast(6'd0, 32'h1234);
    tick(); tick();
    chk("tag0_nowake", ifc.occupancy, 1);
    ifc.flush = 1; tick(); ifc.flush = 0;
    chk("tag0_flushed", ifc.occupancy, 0);

    // wakeup on tag 12
    e = mk(4'd2, 6'd12, 6'd5, 32'd0, 32'd11, 5'd3);
    disp(e, 0, 1);
    tick(); tick();
    chk("wait_rs1", ifc.occupancy, 1);
    e.rs1_data = 32'hDEAD_BEEF;
    sbq.push_back(ex(e));
    bcast(6'd12, 32'hDEAD_BEEF);
    chk("wake_not_same_cycle", ifc.next_execute.valid, 0);
    tick();
    chk("wake_issue", ifc.next_execute.valid, 1);
    chk("wake_occ0", ifc.occupancy, 0);

    // dispatch coinciding with broadcast of tag 9
    e = mk(4'd3, 6'd7, 6'd9, 32'd13, 32'd0, 5'd4);
    ifc.cdb_valid = 1; ifc.cdb_rd_paddr = 6'd9; ifc.cdb_rd_data = 32'hCAFE_0009;
    e.rs2_data = 32'hCAFE_0009;
    sbq.push_back(ex(e));
    e.rs2_data = 32'd0;
    disp(e, 1, 0);
    ifc.cdb_valid = 0;
    tick();
    chk("coincide_occ0", ifc.occupancy, 0);

    // fill, drop 9th, then overlap dispatch + issue
    ifc.alu_ready = 0;
    for (int k = 0; k < 8; k++) begin
      fe[k] = mk(4'(k), 6'd1, 6'd2, 32'd100 + 32'(k), 32'd200 + 32'(k), 5'(k + 8));
      disp(fe[k], 1, 1);
    end
    chk("full_occ", ifc.occupancy, 8);
    chk("full_ready", ifc.dispatch_ready, 0);
    disp(mk(4'd9, 6'd1, 6'd2, 32'd999, 32'd999, 5'd30), 1, 1);
    chk("full_drop", ifc.occupancy, 8);
    n = mk(4'd10, 6'd1, 6'd2, 32'd300, 32'd301, 5'd20);
    sbq.push_back(ex(fe[0]));
    sbq.push_back(ex(fe[1]));
`ifdef ALU_IQ_AGE_SEL_EN
    for (int k = 2; k < 8; k++) sbq.push_back(ex(fe[k]));
    sbq.push_back(ex(n));
`else
    sbq.push_back(ex(n));
    for (int k = 2; k < 8; k++) sbq.push_back(ex(fe[k]));
`endif
    ifc.alu_ready = 1;
    ifc.dispatch_valid = 1; ifc.dispatch_entry = n;
    ifc.dispatch_rs1_ready = 1; ifc.dispatch_rs2_ready = 1;
    tick();
    chk("drain_occ_first", ifc.occupancy, 7);
    chk("drain_v0", ifc.next_execute.valid, 1);
    tick();
    ifc.dispatch_valid = 0;
    chk("overlap_occ", ifc.occupancy, 7);
    chk("drain_v1", ifc.next_execute.valid, 1);
    for (int k = 2; k < 9; k++) begin
      tick();
      chk($sformatf("drain_v%0d", k), ifc.next_execute.valid, 1);
    end
    tick();
    chk("empty_no_issue", ifc.next_execute.valid, 0);
    chk("empty_occ", ifc.occupancy, 0);

    // age vs slot order: C lands in a lower slot than older A
    ifc.alu_ready = 0;
    d0 = mk(4'd4, 6'd30, 6'd1, 32'd0, 32'd40, 5'd5);
    a  = mk(4'd5, 6'd20, 6'd1, 32'd0, 32'd41, 5'd6);
    b  = mk(4'd6, 6'd31, 6'd1, 32'd0, 32'd42, 5'd7);
    c  = mk(4'd7, 6'd20, 6'd1, 32'd0, 32'd43, 5'd9);
    disp(d0, 0, 1); disp(a, 0, 1); disp(b, 0, 1);
    d0.rs1_data = 32'h3030;
    sbq.push_back(ex(d0));
    bcast(6'd30, 32'h3030);
    ifc.alu_ready = 1; tick(); ifc.alu_ready = 0;
    chk("age_d0_out", ifc.next_execute.valid, 1);
    disp(c, 0, 1);
    a.rs1_data = 32'h2020;
    c.rs1_data = 32'h2020;
`ifdef ALU_IQ_AGE_SEL_EN
    sbq.push_back(ex(a)); sbq.push_back(ex(c));
`else
    sbq.push_back(ex(c)); sbq.push_back(ex(a));
`endif
    bcast(6'd20, 32'h2020);
    ifc.alu_ready = 1;
    tick(); tick();
    b.rs1_data = 32'h3131;
    sbq.push_back(ex(b));
    bcast(6'd31, 32'h3131);
    tick();
    chk("age_occ0", ifc.occupancy, 0);

    // flush with 4 valid entries and an output in flight
    ifc.alu_ready = 0;
    for (int k = 0; k < 5; k++) begin
      fe[k] = mk(4'(k), 6'd1, 6'd2, 32'd500 + 32'(k), 32'd600, 5'(k));
      disp(fe[k], 1, 1);
    end
    sbq.push_back(ex(fe[0]));
    ifc.alu_ready = 1; tick(); ifc.alu_ready = 0;
    chk("pre_flush_occ", ifc.occupancy, 4);
    chk("pre_flush_valid", ifc.next_execute.valid, 1);
    ifc.flush = 1;
    disp(mk(4'd11, 6'd1, 6'd2, 32'd777, 32'd777, 5'd11), 1, 1);
    ifc.flush = 0;
    chk("flush_occ", ifc.occupancy, 0);
    chk("flush_valid", ifc.next_execute.valid, 0);
    ifc.alu_ready = 1;
    tick(); tick(); tick();
    chk("flush_not_retained", ifc.occupancy, 0);
    chk("sb_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
